reg_file_seq: RTL and testbench

REG_FILE_SEQ -- requirements
Module: reg_file_seq

---
 rtl/reg_file_pkg.sv | 25 ++
 rtl/reg_file_seq.sv | 134 +++++++++++++
 tb/tb_reg_file_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and enums for the register-file sequencer.
// Covers the command opcodes and the sequencer FSM states.
package reg_file_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  localparam logic [RF_ADDR_W-1:0] LAST_IDX = RF_ADDR_W'(RF_DEPTH - 1);

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_FILL  = 2'd1,
    OP_DUMP  = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    DUMP_RD  = 2'd2,
    DUMP_OUT = 2'd3
  } state_e;

endpackage

// File: rtl/reg_file_seq.sv
// Command-driven sequencer that clears, fills or dumps a 32x32 register file.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
module reg_file_seq
  import reg_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic        busy,
  output logic        done,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_reg,
  output logic [31:0] rf_wr_data,
  output logic [4:0]  rf_rd_reg_1,
  output logic [4:0]  rf_rd_reg_2,
  input  logic [31:0] rf_rd_data_1,
  input  logic [31:0] rf_rd_data_2,
  output logic [1:0]  dbg_state
);

  state_e                 state, state_d;
  logic [RF_ADDR_W-1:0]   idx, idx_d;
  logic [RF_DATA_W-1:0]   fill, fill_d;
  logic                   dump_valid_d, dump_last_d, done_d;
  logic [RF_ADDR_W-1:0]   dump_idx_d;
  logic [RF_DATA_W-1:0]   dump_data_d;
  logic                   unused_rd_2;

  assign unused_rd_2 = ^rf_rd_data_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      fill       <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      fill       <= fill_d;
      dump_valid <= dump_valid_d;
      dump_idx   <= dump_idx_d;
      dump_data  <= dump_data_d;
      dump_last  <= dump_last_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    fill_d       = fill;
    dump_valid_d = dump_valid;
    dump_idx_d   = dump_idx;
    dump_data_d  = dump_data;
    dump_last_d  = dump_last;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLEAR: begin
              fill_d  = '0;
              idx_d   = 5'd1;
              state_d = WRITE;
            end
            OP_FILL: begin
              fill_d  = cmd_data;
              idx_d   = 5'd1;
              state_d = WRITE;
            end
            OP_DUMP: begin
              idx_d   = '0;
              state_d = DUMP_RD;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      WRITE: begin
        // Terminal test before increment so idx never wraps back to x0.
        if (idx == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx + 5'd1;
        end
      end
      DUMP_RD: begin
        dump_data_d  = rf_rd_data_1;
        dump_idx_d   = idx;
        dump_last_d  = (idx == LAST_IDX);
        dump_valid_d = 1'b1;
        state_d      = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx + 5'd1;
            state_d = DUMP_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset kills writes immediately.
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign rf_wr_en    = (state == WRITE);
  assign rf_wr_reg   = (state == WRITE) ? idx : '0;
  assign rf_wr_data  = (state == WRITE) ? fill : '0;
  assign rf_rd_reg_1 = (state == DUMP_RD) ? idx : '0;
  assign rf_rd_reg_2 = '0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench for reg_file_seq with a behavioural 32x32 register file.
// Expected values are hand-derived from the command sequence applied.
module tb_reg_file_seq;
  import reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        busy;
  logic        done;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_reg;
  logic [31:0] rf_wr_data;
  logic [4:0]  rf_rd_reg_1;
  logic [4:0]  rf_rd_reg_2;
  logic [31:0] rf_rd_data_1;
  logic [31:0] rf_rd_data_2;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  reg_file_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .done(done),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .rf_rd_reg_1(rf_rd_reg_1), .rf_rd_reg_2(rf_rd_reg_2),
    .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2),
    .dbg_state(dbg_state)
  );

  // register-file model: stores any write, x0 reads as zero
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
  always @(posedge clk) if (rf_wr_en) rf[rf_wr_reg] <= rf_wr_data;
  assign rf_rd_data_1 = (rf_rd_reg_1 == 5'd0) ? 32'd0 : rf[rf_rd_reg_1];
  assign rf_rd_data_2 = (rf_rd_reg_2 == 5'd0) ? 32'd0 : rf[rf_rd_reg_2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic issue_cmd(input logic [1:0] op, input logic [31:0] data);
    @(negedge clk);
    check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [1:0] op, input logic [31:0] data, input int pulse_at);
    logic [31:0] exp_val;
    int wr_cnt;
    int done_c;
    exp_val = (op == 2'd0) ? 32'd0 : data;
    wr_cnt = 0;
    done_c = 0;
    issue_cmd(op, data);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rf_wr_en) begin
        wr_cnt++;
        check("wr_reg", 32'(rf_wr_reg), 32'(wr_cnt));
        check("wr_data", rf_wr_data, exp_val);
      end
      if (c == 3) check("rd_reg_1_in_write", 32'(rf_rd_reg_1), 32'd0);
      if (c == pulse_at) begin
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
      end
      if (done) begin
        done_c = c;
        break;
      end
    end
    check("wr_count", 32'(wr_cnt), 32'd31);
    check("wr_done_cycle", 32'(done_c), 32'd32);
    check("wr_state_idle", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("no_dump_after_pulse", 32'(busy), 32'd0);
  endtask

  task automatic run_dump(input logic stall, input logic [31:0] exp_val);
    int beat;
    int stall_cnt;
    int done_c;
    logic prev_stall;
    logic [31:0] p_data;
    logic [4:0]  p_idx;
    logic        p_last;
    beat = 0;
    stall_cnt = 0;
    done_c = 0;
    prev_stall = 1'b0;
    p_data = '0;
    p_idx = '0;
    p_last = 1'b0;
    dump_ready = !stall;
    issue_cmd(2'd2, 32'd0);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("hold_valid", 32'(dump_valid), 32'd1);
        check("hold_data", dump_data, p_data);
        check("hold_idx", 32'(dump_idx), 32'(p_idx));
        check("hold_last", 32'(dump_last), 32'(p_last));
      end
      if (stall) begin
        if (dump_valid && dump_idx == 5'd7 && stall_cnt < 5) begin
          dump_ready = 1'b0;
          stall_cnt++;
        end else begin
          dump_ready = (c % 3) != 0;
        end
      end
      if (dump_valid && dump_ready) begin
        check("dump_idx", 32'(dump_idx), 32'(beat));
        check("dump_data", dump_data, (beat == 0) ? 32'd0 : exp_val);
        check("dump_last", 32'(dump_last), 32'(beat == 31));
        beat++;
      end
      prev_stall = dump_valid && !dump_ready;
      p_data = dump_data;
      p_idx  = dump_idx;
      p_last = dump_last;
      if (done) begin
        done_c = c;
        break;
      end
    end
    check("dump_beats", 32'(beat), 32'd32);
    if (stall) check("stall_cycles", 32'(stall_cnt), 32'd5);
    else       check("dump_done_cycle", 32'(done_c), 32'd65);
    check("dump_valid_end", 32'(dump_valid), 32'd0);
    dump_ready = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // FILL then verify contents through the model
    run_write(2'd1, 32'hDEAD_BEEF, 0);
    check("x0_zero", rf[0], 32'd0);
    for (int i = 1; i < 32; i++) check("fill_reg", rf[i], 32'hDEAD_BEEF);

    run_dump(1'b0, 32'hDEAD_BEEF);
    run_dump(1'b1, 32'hDEAD_BEEF);

    // CLEAR with an ignored DUMP request mid-way
    run_write(2'd0, 32'h1234_5678, 5);
    for (int i = 0; i < 32; i++) check("clear_reg", rf[i], 32'd0);
    run_dump(1'b0, 32'd0);

    // reset in the middle of a FILL at idx 10
    begin
      logic found;
      found = 1'b0;
      issue_cmd(2'd1, 32'hA5A5_0F0F);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (rf_wr_en && rf_wr_reg == 5'd10) begin
          found = 1'b1;
          break;
        end
      end
      check("reached_idx10", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_wr_en", 32'(rf_wr_en), 32'd0);
      check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
      check("rst_mid_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("no_resume_wr", 32'(rf_wr_en), 32'd0);
      check("no_resume_busy", 32'(busy), 32'd0);
      for (int i = 1; i < 10; i++) check("partial_new", rf[i], 32'hA5A5_0F0F);
      for (int i = 10; i < 32; i++) check("partial_old", rf[i], 32'd0);
    end

    // reset while a dump beat is pending
    begin
      logic seen;
      seen = 1'b0;
      dump_ready = 1'b0;
      issue_cmd(2'd2, 32'd0);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (dump_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("dump_pending", 32'(seen), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_dump_drop", 32'(dump_valid), 32'd0);
      check("rst_dump_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dump_ready = 1'b1;
    end

    // reserved opcode: no rf activity, done one cycle after accept
    issue_cmd(2'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rsvd_done", 32'(done), 32'd1);
    check("rsvd_busy", 32'(busy), 32'd0);
    check("rsvd_wr_en", 32'(rf_wr_en), 32'd0);
    check("rsvd_rd_reg", 32'(rf_rd_reg_1), 32'd0);
    check("rsvd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check("rsvd_done_drop", 32'(done), 32'd0);
    check("rd_reg_2_zero", 32'(rf_rd_reg_2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
